// File: rtl/alu_slice_pkg.sv
// Shared encodings for the alu_slice operand-source, function and destination
// controls, plus bit positions within the registered status flags.
package alu_slice_pkg;

    typedef enum logic [2:0] {AQ, AB, ZQ, ZB, ZA, DA, DQ, DZ} src_e;
    typedef enum logic [2:0] {ADD, SUBR, SUBS, OR, AND, NOTRS, EXOR, EXNOR} op_e;
    typedef enum logic [2:0] {QREG, NOP, RAMA, RAMF, RAMQD, RAMD, RAMQU, RAMU} dest_e;

    localparam int unsigned FLAG_OVR  = 0;
    localparam int unsigned FLAG_MSB  = 1;
    localparam int unsigned FLAG_ZERO = 2;
    localparam int unsigned FLAG_COUT = 3;

endpackage

// File: rtl/alu_slice_regfile.sv
// DEPTH x WIDTH register file: async clear, two combinational read ports,
// one synchronous write port. Reads see the pre-write value in the write cycle.
module alu_slice_regfile #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_slice.sv
// Parametrised 2901-style bit slice: register file, Q register, 8x8x8 ALU with
// carry/overflow/lookahead outputs, shift linkage and a registered flag word.
module alu_slice
    import alu_slice_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    aSel,
    input  logic [AW-1:0]    bSel,
    input  logic [2:0]       aluSrc,
    input  logic [2:0]       aluOp,
    input  logic [2:0]       aluDest,
    input  logic             cin,
    input  logic             oe,
    input  logic             flagWe,
    input  logic             ramInLsb,
    input  logic             ramInMsb,
    input  logic             qInLsb,
    input  logic             qInMsb,
    output logic [WIDTH-1:0] yout,
    output logic             cout,
    output logic             fzero,
    output logic             fmsb,
    output logic             ovr,
    output logic             gOut,
    output logic             pOut,
    output logic             ramOutLsb,
    output logic             ramOutMsb,
    output logic             qOutLsb,
    output logic             qOutMsb,
    output logic [3:0]       flagsReg
);

    src_e  src;
    op_e   op;
    dest_e dest;

    logic [WIDTH-1:0] a, b, q, q_next, r, s, x, z, f, y, wdata;
    logic [WIDTH:0]   sum;
    logic [3:0]       flags;
    logic             arith, we, gen;

    assign src  = src_e'(aluSrc);
    assign op   = op_e'(aluOp);
    assign dest = dest_e'(aluDest);

    alu_slice_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (we & ce),
        .waddr   (bSel),
        .wdata   (wdata),
        .raddr_a (aSel),
        .raddr_b (bSel),
        .rdata_a (a),
        .rdata_b (b)
    );

    always_comb begin
        r = '0;
        s = '0;
        case (src)
            AQ:      begin r = a;   s = q;  end
            AB:      begin r = a;   s = b;  end
            ZQ:      s = q;
            ZB:      s = b;
            ZA:      s = a;
            DA:      begin r = din; s = a;  end
            DQ:      begin r = din; s = q;  end
            DZ:      r = din;
            default: ;
        endcase
    end

    // x/z are the adder operands after the optional inversion of R or S.
    always_comb begin
        x     = r;
        z     = s;
        arith = 1'b1;
        case (op)
            ADD:     ;
            SUBR:    x = ~r;
            SUBS:    z = ~s;
            default: arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, z} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        gen = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            gen = (x[i] & z[i]) | ((x[i] | z[i]) & gen);
        end
    end

    always_comb begin
        case (op)
            OR:      f = r | s;
            AND:     f = r & s;
            NOTRS:   f = ~r & s;
            EXOR:    f = r ^ s;
            EXNOR:   f = ~(r ^ s);
            default: f = sum[WIDTH-1:0];
        endcase
    end

    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign cout  = arith & sum[WIDTH];
    assign ovr   = arith & (sum[WIDTH-1] ^ x[WIDTH-1] ^ z[WIDTH-1] ^ sum[WIDTH]);
    assign gOut  = arith & gen;
    assign pOut  = arith & (&(x | z));
    assign fzero = (f == '0);
    assign fmsb  = f[WIDTH-1];

    always_comb begin
        y         = f;
        we        = 1'b0;
        wdata     = f;
        q_next    = q;
        ramOutLsb = 1'b0;
        ramOutMsb = 1'b0;
        qOutLsb   = 1'b0;
        qOutMsb   = 1'b0;
        case (dest)
            QREG: q_next = f;
            NOP:  ;
            RAMA: begin y = a; we = 1'b1; end
            RAMF: we = 1'b1;
            RAMQD, RAMD: begin
                we        = 1'b1;
                wdata     = {ramInMsb, f[WIDTH-1:1]};
                ramOutLsb = f[0];
                if (dest == RAMQD) begin
                    q_next  = {qInMsb, q[WIDTH-1:1]};
                    qOutLsb = q[0];
                end
            end
            RAMQU, RAMU: begin
                we        = 1'b1;
                wdata     = {f[WIDTH-2:0], ramInLsb};
                ramOutMsb = f[WIDTH-1];
                if (dest == RAMQU) begin
                    q_next  = {q[WIDTH-2:0], qInLsb};
                    qOutMsb = q[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

    assign yout = oe ? y : '0;

    always_comb begin
        flags            = '0;
        flags[FLAG_COUT] = cout;
        flags[FLAG_ZERO] = fzero;
        flags[FLAG_MSB]  = fmsb;
        flags[FLAG_OVR]  = ovr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q        <= '0;
            flagsReg <= '0;
        end else if (ce) begin
            q <= q_next;
            if (flagWe) begin
                flagsReg <= flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_slice.sv
// Directed bench for alu_slice: an 8-bit and a 4-bit instance share the control
// inputs; each step checks hand-computed results on the instance of interest.
module tb_alu_slice;

    logic       clock, reset, ce, cin, oe, flagWe;
    logic       ramInLsb, ramInMsb, qInLsb, qInMsb;
    logic [3:0] aSel, bSel;
    logic [2:0] aluSrc, aluOp, aluDest;

    logic [7:0] din8, y8;
    logic       cout8, fzero8, fmsb8, ovr8, g8, p8, rol8, rom8, qol8, qom8;
    logic [3:0] flags8;

    logic [3:0] din4, y4;
    logic       cout4, fzero4, fmsb4, ovr4, g4, p4, rol4, rom4, qol4, qom4;
    logic [3:0] flags4;

    int n_checks = 0;
    int n_fail   = 0;

    alu_slice #(.WIDTH(8), .DEPTH(16)) u8 (
        .clock(clock), .reset(reset), .ce(ce), .din(din8), .aSel(aSel), .bSel(bSel),
        .aluSrc(aluSrc), .aluOp(aluOp), .aluDest(aluDest), .cin(cin), .oe(oe),
        .flagWe(flagWe), .ramInLsb(ramInLsb), .ramInMsb(ramInMsb), .qInLsb(qInLsb),
        .qInMsb(qInMsb), .yout(y8), .cout(cout8), .fzero(fzero8), .fmsb(fmsb8),
        .ovr(ovr8), .gOut(g8), .pOut(p8), .ramOutLsb(rol8), .ramOutMsb(rom8),
        .qOutLsb(qol8), .qOutMsb(qom8), .flagsReg(flags8)
    );

    alu_slice #(.WIDTH(4), .DEPTH(16)) u4 (
        .clock(clock), .reset(reset), .ce(ce), .din(din4), .aSel(aSel), .bSel(bSel),
        .aluSrc(aluSrc), .aluOp(aluOp), .aluDest(aluDest), .cin(cin), .oe(oe),
        .flagWe(flagWe), .ramInLsb(ramInLsb), .ramInMsb(ramInMsb), .qInLsb(qInLsb),
        .qInMsb(qInMsb), .yout(y4), .cout(cout4), .fzero(fzero4), .fmsb(fmsb4),
        .ovr(ovr4), .gOut(g4), .pOut(p4), .ramOutLsb(rol4), .ramOutMsb(rom4),
        .qOutLsb(qol4), .qOutMsb(qom4), .flagsReg(flags4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // src: 0 AQ,1 AB,2 ZQ,3 ZB,4 ZA,5 DA,6 DQ,7 DZ
    // op: 0 ADD,1 SUBR,2 SUBS,3 OR,4 AND,5 NOTRS,6 EXOR,7 EXNOR
    // dest: 0 QREG,1 NOP,2 RAMA,3 RAMF,4 RAMQD,5 RAMD,6 RAMQU,7 RAMU
    initial begin
        reset = 1'b1; ce = 1'b1; oe = 1'b1; flagWe = 1'b0; cin = 1'b0;
        ramInLsb = 1'b0; ramInMsb = 1'b0; qInLsb = 1'b0; qInMsb = 1'b0;
        aSel = 4'd0; bSel = 4'd0; din8 = 8'h00; din4 = 4'h0;
        aluSrc = 3'd2; aluOp = 3'd3; aluDest = 3'd1;

        #3;
        chk("rst_flags8", flags8, 4'h0);
        chk("rst_flags4", flags4, 4'h0);
        chk("rst_q8", y8, 8'h00);
        chk("rst_q4", y4, 4'h0);
        chk("rst_fzero8", fzero8, 1'b1);
        #1 reset = 1'b0;
        tick();

        // Build nonzero state, then pulse reset mid-cycle.
        aluSrc = 3'd7; aluOp = 3'd0; din8 = 8'hAA; aluDest = 3'd0; flagWe = 1'b1;
        tick();
        aluDest = 3'd3; bSel = 4'd2; flagWe = 1'b0;
        tick();
        aluSrc = 3'd2; aluOp = 3'd3; aluDest = 3'd1;
        #1;
        chk("pre_q8", y8, 8'hAA);
        chk("pre_flags8", flags8, 4'h2);
        #1 reset = 1'b1;
        #1;
        chk("midrst_flags8", flags8, 4'h0);
        chk("midrst_q8", y8, 8'h00);
        aluSrc = 3'd4; aSel = 4'd2;
        #1;
        chk("midrst_r2_8", y8, 8'h00);
        #2 reset = 1'b0;
        tick();

        // 8-bit: 7F + 0 + 1 overflows into the sign bit.
        aluSrc = 3'd7; aluOp = 3'd0; din8 = 8'h7F; cin = 1'b1; aluDest = 3'd0; flagWe = 1'b1;
        #1;
        chk("ovf_y8", y8, 8'h80);
        chk("ovf_ovr8", ovr8, 1'b1);
        chk("ovf_cout8", cout8, 1'b0);
        chk("ovf_fmsb8", fmsb8, 1'b1);
        chk("ovf_fzero8", fzero8, 1'b0);
        tick();
        aluSrc = 3'd2; aluOp = 3'd3; cin = 1'b0; aluDest = 3'd1; flagWe = 1'b0;
        #1;
        chk("ovf_q8", y8, 8'h80);
        chk("ovf_flags8", flags8, 4'b0011);

        // 4-bit: r3 = F, then r3 + r3.
        aluSrc = 3'd7; aluOp = 3'd0; din4 = 4'hF; aluDest = 3'd3; bSel = 4'd3;
        tick();
        aluSrc = 3'd1; aSel = 4'd3; aluDest = 3'd1;
        #1;
        chk("add_y4", y4, 4'hE);
        chk("add_cout4", cout4, 1'b1);
        chk("add_ovr4", ovr4, 1'b0);
        chk("add_g4", g4, 1'b1);
        chk("add_p4", p4, 1'b1);

        // Subtract and logic functions on D.
        aluSrc = 3'd7; din4 = 4'h3; aluOp = 3'd2; cin = 1'b1;
        #1;
        chk("subs_y4", y4, 4'h3);
        chk("subs_cout4", cout4, 1'b1);
        chk("subs_g4", g4, 1'b1);
        aluOp = 3'd1;
        #1;
        chk("subr_y4", y4, 4'hD);
        chk("subr_cout4", cout4, 1'b0);
        chk("subr_p4", p4, 1'b0);
        aluOp = 3'd7; cin = 1'b0;
        #1;
        chk("exnor_y4", y4, 4'hC);
        chk("exnor_p4", p4, 1'b0);

        // Down-shift into r1 with ramInMsb=1.
        aluOp = 3'd0; din4 = 4'h9; aluDest = 3'd3; bSel = 4'd1;
        tick();
        aluSrc = 3'd3; aluOp = 3'd3; aluDest = 3'd5; ramInMsb = 1'b1;
        #1;
        chk("dsh_y4", y4, 4'h9);
        chk("dsh_rol4", rol4, 1'b1);
        chk("dsh_rom4", rom4, 1'b0);
        chk("dsh_qol4", qol4, 1'b0);
        tick();
        ramInMsb = 1'b0; aluSrc = 3'd4; aSel = 4'd1; aluDest = 3'd1;
        #1;
        chk("dsh_r1", y4, 4'hC);
        chk("dsh_rol_nop", rol4, 1'b0);

        // Q up-shift then down-shift.
        aluSrc = 3'd7; aluOp = 3'd0; din4 = 4'h8; aluDest = 3'd0;
        tick();
        aluSrc = 3'd2; aluOp = 3'd3; aluDest = 3'd6; qInLsb = 1'b1; bSel = 4'd7;
        #1;
        chk("ush_qom4", qom4, 1'b1);
        chk("ush_rom4", rom4, 1'b1);
        chk("ush_qol4", qol4, 1'b0);
        tick();
        aluDest = 3'd4; qInLsb = 1'b0; qInMsb = 1'b1;
        #1;
        chk("ush_q4", y4, 4'h1);
        chk("qd_qol4", qol4, 1'b1);
        chk("qd_rol4", rol4, 1'b1);
        chk("qd_qom4", qom4, 1'b0);
        tick();
        aluDest = 3'd1; qInMsb = 1'b0;
        #1;
        chk("qd_q4", y4, 4'h8);

        // Clock enable low: nothing changes over five edges.
        aluSrc = 3'd7; aluOp = 3'd0; din4 = 4'h0; flagWe = 1'b1;
        tick();
        ce = 1'b0; aluDest = 3'd3; bSel = 4'd3; din4 = 4'h5;
        repeat (5) tick();
        chk("ce0_flags4", flags4, 4'b0100);
        chk("ce0_live_y4", y4, 4'h5);
        ce = 1'b1; flagWe = 1'b0; aluDest = 3'd1; aluSrc = 3'd4; aSel = 4'd3;
        #1;
        chk("ce0_r3", y4, 4'hF);
        aluSrc = 3'd2;
        #1;
        chk("ce0_q4", y4, 4'h8);

        // Output enable gates only yout.
        oe = 1'b0; aluSrc = 3'd7; din4 = 4'h0;
        #1;
        chk("oe0_y_z", y4, 4'h0);
        chk("oe0_fzero1", fzero4, 1'b1);
        din4 = 4'h6;
        #1;
        chk("oe0_y_nz", y4, 4'h0);
        chk("oe0_fzero0", fzero4, 1'b0);
        oe = 1'b1;
        #1;
        chk("oe1_y4", y4, 4'h6);

        // Same-cycle read/write of r5.
        din4 = 4'hA; aluDest = 3'd2; aSel = 4'd5; bSel = 4'd5;
        #1;
        chk("rw_old_r5", y4, 4'h0);
        tick();
        chk("rw_new_r5", y4, 4'hA);
        aluDest = 3'd1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
